// File: rtl/tmma_left_feeder_pkg.sv
// Shared constants, data-type codes and FSM state type for the left-edge
// operand feeder of the systolic PE array.
package tmma_left_feeder_pkg;

  localparam int PE_INPUT_DATA_WIDTH  = 32;
  localparam int TMMA_CNT_WIDTH       = 8;
  localparam int TMMA_PRECISION_WIDTH = 2;

  localparam logic PE_DATA_TYPE_A = 1'b1;
  localparam logic PE_DATA_TYPE_C = 1'b0;

  typedef enum logic [1:0] {
    FEED_IDLE   = 2'd0,
    FEED_STREAM = 2'd1,
    FEED_DRAIN  = 2'd2,
    FEED_DONE   = 2'd3
  } feed_state_e;

  // Cycles spent in DRAIN so that DONE coincides with the last row's final beat;
  // a single-row array still passes through DRAIN once.
  function automatic int drain_cycles(input int rows);
    return (rows > 1) ? rows - 1 : 1;
  endfunction

endpackage

// File: rtl/tmma_left_feeder_if.sv
// Command, operand-source and left-edge PE bus of the feeder. The master
// modport is the feeder itself; the slave modport is its environment.
interface tmma_left_feeder_if
  import tmma_left_feeder_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int DATA_W = PE_INPUT_DATA_WIDTH,
  parameter int CNT_W  = TMMA_CNT_WIDTH,
  parameter int PREC_W = TMMA_PRECISION_WIDTH
);

  logic                     cmd_valid_i;
  logic                     cmd_ready_o;
  logic [CNT_W-1:0]         cmd_k_i;
  logic [PREC_W-1:0]        cmd_precision_i;
  logic                     src_valid_i;
  logic                     src_ready_o;
  logic [ROWS*DATA_W-1:0]   src_data_i;
  logic [ROWS-1:0]          left_data_valid_o;
  logic [ROWS*CNT_W-1:0]    left_data_cnt_o;
  logic [ROWS-1:0]          left_data_type_o;
  logic [ROWS*PREC_W-1:0]   left_precision_o;
  logic [ROWS*DATA_W-1:0]   left_data_o;
  logic                     done_o;
  logic                     busy_o;

  modport master (
    input  cmd_valid_i, cmd_k_i, cmd_precision_i, src_valid_i, src_data_i,
    output cmd_ready_o, src_ready_o, left_data_valid_o, left_data_cnt_o,
           left_data_type_o, left_precision_o, left_data_o, done_o, busy_o
  );

  modport slave (
    output cmd_valid_i, cmd_k_i, cmd_precision_i, src_valid_i, src_data_i,
    input  cmd_ready_o, src_ready_o, left_data_valid_o, left_data_cnt_o,
           left_data_type_o, left_precision_o, left_data_o, done_o, busy_o
  );

endinterface

// File: rtl/tmma_skew_line.sv
// DEPTH-stage delay line for one row's {valid, cnt, type, precision, data} slot;
// the whole line clears synchronously on rst.
module tmma_skew_line #(
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 8,
  parameter int PREC_W = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic              type_i,
  input  logic [PREC_W-1:0] prec_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              type_o,
  output logic [PREC_W-1:0] prec_o,
  output logic [DATA_W-1:0] data_o
);

  localparam int W = 1 + CNT_W + 1 + PREC_W + DATA_W;

  logic [DEPTH-1:0][W-1:0] stage_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= {valid_i, cnt_i, type_i, prec_i, data_i};
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign {valid_o, cnt_o, type_o, prec_o, data_o} = stage_q[DEPTH-1];

endmodule

// File: rtl/tmma_left_feeder.sv
// Left-edge transmitter: accepts a tile command, streams K operand beats and
// skews row r by r cycles into the PE array, then pulses done_o.
module tmma_left_feeder
  import tmma_left_feeder_pkg::*;
#(
  parameter int ROWS   = 4,
  parameter int DATA_W = PE_INPUT_DATA_WIDTH,
  parameter int CNT_W  = TMMA_CNT_WIDTH,
  parameter int PREC_W = TMMA_PRECISION_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  tmma_left_feeder_if.master bus
);

  localparam int DRAIN_LEN = drain_cycles(ROWS);
  localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);

  feed_state_e       state_q, state_d;
  logic [CNT_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [PREC_W-1:0] prec_q, prec_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;

  logic cmd_ready;
  logic src_ready;
  logic done;
  logic busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FEED_IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      prec_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      prec_q  <= prec_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    beat_d    = beat_q;
    prec_d    = prec_q;
    drain_d   = drain_q;
    cmd_ready = 1'b0;
    src_ready = 1'b0;
    done      = 1'b0;
    busy      = 1'b1;
    case (state_q)
      FEED_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (bus.cmd_valid_i) begin
          k_d     = bus.cmd_k_i;
          prec_d  = bus.cmd_precision_i;
          beat_d  = '0;
          drain_d = '0;
          state_d = (bus.cmd_k_i == '0) ? FEED_DONE : FEED_STREAM;
        end
      end
      FEED_STREAM: begin
        src_ready = 1'b1;
        if (bus.src_valid_i) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == k_q - 1'b1) begin
            state_d = FEED_DRAIN;
          end
        end
      end
      FEED_DRAIN: begin
        // Leave so that DONE lands on the cycle the last row shows beat K-1.
        drain_d = drain_q + 1'b1;
        if (drain_q == DRAIN_W'(DRAIN_LEN - 1)) begin
          state_d = FEED_DONE;
        end
      end
      FEED_DONE: begin
        done    = 1'b1;
        state_d = FEED_IDLE;
      end
      default: begin
        state_d = FEED_IDLE;
      end
    endcase
  end

  // A slot enters every skew line each cycle; bubbles travel as all-zero slots.
  logic                   slot_valid;
  logic [CNT_W-1:0]       slot_cnt;
  logic                   slot_type;
  logic [PREC_W-1:0]      slot_prec;
  logic [ROWS*DATA_W-1:0] slot_data;

  assign slot_valid = src_ready & bus.src_valid_i;
  assign slot_cnt   = slot_valid ? beat_q : '0;
  assign slot_type  = slot_valid ? PE_DATA_TYPE_A : PE_DATA_TYPE_C;
  assign slot_prec  = slot_valid ? prec_q : '0;
  assign slot_data  = slot_valid ? bus.src_data_i : '0;

  logic [ROWS-1:0]        left_valid;
  logic [ROWS*CNT_W-1:0]  left_cnt;
  logic [ROWS-1:0]        left_type;
  logic [ROWS*PREC_W-1:0] left_prec;
  logic [ROWS*DATA_W-1:0] left_data;

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
      tmma_skew_line #(
        .DEPTH (gi + 1),
        .CNT_W (CNT_W),
        .PREC_W(PREC_W),
        .DATA_W(DATA_W)
      ) u_skew (
        .clk    (clk),
        .rst    (rst),
        .valid_i(slot_valid),
        .cnt_i  (slot_cnt),
        .type_i (slot_type),
        .prec_i (slot_prec),
        .data_i (slot_data[gi*DATA_W +: DATA_W]),
        .valid_o(left_valid[gi]),
        .cnt_o  (left_cnt[gi*CNT_W +: CNT_W]),
        .type_o (left_type[gi]),
        .prec_o (left_prec[gi*PREC_W +: PREC_W]),
        .data_o (left_data[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign bus.cmd_ready_o       = cmd_ready;
  assign bus.src_ready_o       = src_ready;
  assign bus.done_o            = done;
  assign bus.busy_o            = busy;
  assign bus.left_data_valid_o = left_valid;
  assign bus.left_data_cnt_o   = left_cnt;
  assign bus.left_data_type_o  = left_type;
  assign bus.left_precision_o  = left_prec;
  assign bus.left_data_o       = left_data;

endmodule
